// File: rtl/fp_issue_pkg.sv
// fp_issue_pkg: shared types and constants for the fp_add_issuer front end.
//   - op codes driven to / accepted from the float_point_add unit
//   - issuer FSM state encoding
//   - quiet NaN returned on illegal ops and timeouts
//   - request record buffered in the request FIFO (66 bits)
package fp_issue_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  // Only add and sub ever reach the adder.
  function automatic logic op_legal(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/fp_add_issuer_if.sv
// fp_add_issuer_if: bundle of the issuer's request, adder and response signals.
//   request  : iReqValid/oReqReady handshake carrying iReqA, iReqB, iReqOp
//   adder    : oA/oB/oOp single-cycle issue pulse, iF/iDone completion
//   response : oResValid/iResReady handshake carrying oResF, oResErr
//   status   : oStray (sticky unexpected iDone)
// modport slave  - the issuer's view
// modport master - the environment's view (upstream, adder, consumer)
interface fp_add_issuer_if;

  logic        iReqValid;
  logic        oReqReady;
  logic [31:0] iReqA;
  logic [31:0] iReqB;
  logic [1:0]  iReqOp;
  logic [31:0] oA;
  logic [31:0] oB;
  logic [1:0]  oOp;
  logic [31:0] iF;
  logic        iDone;
  logic        oResValid;
  logic        iResReady;
  logic [31:0] oResF;
  logic        oResErr;
  logic        oStray;

  modport slave (
    input  iReqValid, iReqA, iReqB, iReqOp, iF, iDone, iResReady,
    output oReqReady, oA, oB, oOp, oResValid, oResF, oResErr, oStray
  );

  modport master (
    output iReqValid, iReqA, iReqB, iReqOp, iF, iDone, iResReady,
    input  oReqReady, oA, oB, oOp, oResValid, oResF, oResErr, oStray
  );

endinterface

// File: rtl/fp_req_fifo.sv
// fp_req_fifo: synchronous request FIFO, DEPTH entries of req_t.
//   clk, resetn : clock, synchronous active-low flush
//   push, din   : write din when push (caller guarantees !full)
//   pop         : drop head when pop (caller guarantees !empty)
//   head        : current head entry (valid when !empty)
//   full, empty : derived from a registered occupancy count
module fp_req_fifo
  import fp_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  req_t din,
  input  logic pop,
  output req_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fp_add_issuer.sv
// fp_add_issuer: initiator front end for the float_point_add unit.
// Buffers add/sub requests, issues one at a time to the adder as a single
// cycle oA/oB/oOp pulse, waits for iDone and returns the result over a
// valid/ready response channel, strictly in request order.
//   clk    : clock
//   resetn : synchronous active-low reset (flushes FIFO, FSM to IDLE)
//   bus    : fp_add_issuer_if.slave (request, adder, response, oStray)
// Build option: FP_ISSUE_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and
// answers an expired operation with oResErr=1 / QNAN.
//
// state | meaning
// IDLE  | waiting for a FIFO entry; illegal op is answered directly
// ISSUE | one-cycle adder pulse from FIFO head, head popped
// WAIT  | one operation outstanding, waiting for iDone
// RESP  | result held on oResF/oResErr until iResReady
module fp_add_issuer
  import fp_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input logic           clk,
  input logic           resetn,
  fp_add_issuer_if.slave bus
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fp_add_issuer: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fp_add_issuer: TIMEOUT must be >= 1");
  end

  state_t      state;
  req_t        din;
  req_t        head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;
  logic        rv_q;
  logic [31:0] f_q;
  logic        err_q;
  logic        stray_q;

`ifdef FP_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tmr;
`endif

  assign din  = '{op: bus.iReqOp, a: bus.iReqA, b: bus.iReqB};
  // No-ops complete the handshake but never occupy an entry.
  assign push = bus.iReqValid && !full && (bus.iReqOp != OP_IDLE);
  assign pop  = (state == ST_ISSUE) ||
                (state == ST_IDLE && !empty && !op_legal(head.op));

  fp_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (din),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_IDLE;
      rv_q    <= 1'b0;
      f_q     <= '0;
      err_q   <= 1'b0;
      stray_q <= 1'b0;
`ifdef FP_ISSUE_TIMEOUT_EN
      tmr     <= '0;
`endif
    end else begin
      // Any completion the FSM is not waiting for (including one that lands
      // on the ISSUE cycle) is reported and otherwise ignored.
      if (bus.iDone && state != ST_WAIT) stray_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (op_legal(head.op)) begin
              a_q   <= head.a;
              b_q   <= head.b;
              op_q  <= head.op;
              state <= ST_ISSUE;
            end else begin
              f_q   <= QNAN;
              err_q <= 1'b1;
              rv_q  <= 1'b1;
              state <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          a_q   <= '0;
          b_q   <= '0;
          op_q  <= OP_IDLE;
          state <= ST_WAIT;
`ifdef FP_ISSUE_TIMEOUT_EN
          // Down-counter: terminal count 0 marks the TIMEOUT-th WAIT cycle.
          tmr   <= TW'(TIMEOUT - 1);
`endif
        end
        ST_WAIT: begin
          if (bus.iDone) begin
            f_q   <= bus.iF;
            err_q <= 1'b0;
            rv_q  <= 1'b1;
            state <= ST_RESP;
          end
`ifdef FP_ISSUE_TIMEOUT_EN
          else if (tmr == '0) begin
            f_q   <= QNAN;
            err_q <= 1'b1;
            rv_q  <= 1'b1;
            state <= ST_RESP;
          end else begin
            tmr <= tmr - 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (bus.iResReady) begin
            rv_q  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.oReqReady = !full;
  assign bus.oA        = a_q;
  assign bus.oB        = b_q;
  assign bus.oOp       = op_q;
  assign bus.oResValid = rv_q;
  assign bus.oResF     = f_q;
  assign bus.oResErr   = err_q;
  assign bus.oStray    = stray_q;

endmodule

// File: tb/tb_fp_add_issuer.sv
// tb_fp_add_issuer: directed, table-driven bench for fp_add_issuer with a
// 3-cycle behavioural adder (results looked up from the vector table).
module tb_fp_add_issuer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fp_add_issuer_if bus ();

  fp_add_issuer #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] f;
    logic        err;
    logic        resp;
  } vec_t;

  vec_t vecs [7];

  int n_cmp = 0;
  int n_bad = 0;
  int issue_cnt = 0;
  int rv_cnt = 0;
  logic [1:0] last_op = 2'b00;

  // Adder model: samples the pulse, raises done so the issuer sees it on
  // the third edge after sampling.
  bit          adder_en = 1'b1;
  bit          stray_inj = 1'b0;
  bit          p1, p2, p3;
  logic [31:0] r1, r2, r3;

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    for (int i = 0; i < 7; i++)
      if (vecs[i].a == a && vecs[i].b == b && vecs[i].op == op) return vecs[i].f;
    return 32'hBAD0_0000 ^ a;
  endfunction

  always @(posedge clk) begin
    p1 <= (bus.oOp != 2'b00);
    r1 <= ref_add(bus.oA, bus.oB, bus.oOp);
    p2 <= p1;
    r2 <= r1;
    p3 <= p2;
    r3 <= r2;
  end

  assign bus.iDone = (p3 && adder_en) || stray_inj;
  assign bus.iF    = r3;

  always @(posedge clk) begin
    if (bus.oOp != 2'b00) begin
      issue_cnt++;
      last_op = bus.oOp;
    end
    if (bus.oResValid) rv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rst_chk(input string pfx);
    chk({pfx, "_a"}, bus.oA, 0);
    chk({pfx, "_b"}, bus.oB, 0);
    chk({pfx, "_f"}, bus.oResF, 0);
    // {oOp, oResValid, oResErr, oStray, oReqReady}
    chk({pfx, "_ctl"}, 32'({bus.oOp, bus.oResValid, bus.oResErr, bus.oStray, bus.oReqReady}),
        32'h1);
  endtask

  task automatic push(input vec_t v);
    bus.iReqValid = 1'b1;
    bus.iReqA     = v.a;
    bus.iReqB     = v.b;
    bus.iReqOp    = v.op;
    for (int i = 0; i < 50 && !bus.oReqReady; i++) tick();
    chk("push_ready", 32'(bus.oReqReady), 1);
    tick();
    bus.iReqValid = 1'b0;
  endtask

  task automatic get_resp(input string nm, input logic [31:0] f, input logic err);
    bus.iResReady = 1'b1;
    for (int i = 0; i < 50 && !bus.oResValid; i++) tick();
    chk({nm, "_valid"}, 32'(bus.oResValid), 1);
    chk({nm, "_f"}, bus.oResF, f);
    chk({nm, "_err"}, 32'(bus.oResErr), 32'(err));
    tick();
    bus.iResReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rv0, acc, hold_bad;
    logic rdy;

    vecs[0] = '{32'h4148_0000, 32'h4108_0000, 2'b01, 32'h41A8_0000, 1'b0, 1'b1};
    vecs[1] = '{32'h4450_0000, 32'h4120_0000, 2'b10, 32'h444D_8000, 1'b0, 1'b1};
    vecs[2] = '{32'h3FE0_0000, 32'hBFA8_0000, 2'b01, 32'h3EE0_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h3F80_0000, 32'h3F80_0000, 2'b01, 32'h4000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h4000_0000, 32'h4040_0000, 2'b10, 32'hBF80_0000, 1'b0, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 32'h7FC0_0000, 1'b1, 1'b1};
    vecs[6] = '{32'h3F80_0000, 32'h3F80_0000, 2'b00, 32'h0000_0000, 1'b0, 1'b0};

    resetn        = 1'b0;
    bus.iReqValid = 1'b0;
    bus.iReqA     = '0;
    bus.iReqB     = '0;
    bus.iReqOp    = 2'b00;
    bus.iResReady = 1'b0;
    repeat (3) tick();
    rst_chk("reset");
    resetn = 1'b1;
    tick();

    // Table: one request at a time, response and issue-count per vector.
    for (int i = 0; i < 7; i++) begin
      c0 = issue_cnt;
      push(vecs[i]);
      if (vecs[i].resp) begin
        get_resp($sformatf("v%0d", i), vecs[i].f, vecs[i].err);
      end else begin
        rv0 = rv_cnt;
        repeat (8) tick();
        chk($sformatf("v%0d_no_resp", i), rv_cnt - rv0, 0);
      end
      chk($sformatf("v%0d_issues", i), issue_cnt - c0,
          (vecs[i].op == 2'b01 || vecs[i].op == 2'b10) ? 1 : 0);
      if (vecs[i].op == 2'b01 || vecs[i].op == 2'b10)
        chk($sformatf("v%0d_op", i), 32'(last_op), 32'(vecs[i].op));
    end

    // Latency from acceptance to pulse and from done to response valid.
    bus.iReqValid = 1'b1;
    bus.iReqA     = vecs[3].a;
    bus.iReqB     = vecs[3].b;
    bus.iReqOp    = vecs[3].op;
    tick();
    bus.iReqValid = 1'b0;
    chk("lat_n_op", 32'(bus.oOp), 0);
    tick();
    chk("lat_n1_op", 32'(bus.oOp), 32'h1);
    chk("lat_n1_a", bus.oA, vecs[3].a);
    tick();
    chk("lat_n2_op", 32'(bus.oOp), 0);
    chk("lat_n2_a", bus.oA, 0);
    tick();
    tick();
    chk("lat_n4_rv", 32'(bus.oResValid), 0);
    tick();
    chk("lat_n5_rv", 32'(bus.oResValid), 1);
    get_resp("lat", vecs[3].f, 1'b0);

    // Back-to-back: second op must wait for the first response handshake.
    c0 = issue_cnt;
    push(vecs[1]);
    push(vecs[2]);
    for (int i = 0; i < 50 && !bus.oResValid; i++) tick();
    chk("b2b_first_f", bus.oResF, vecs[1].f);
    hold_bad = 0;
    repeat (10) begin
      tick();
      if (bus.oResValid !== 1'b1 || bus.oResF !== vecs[1].f) hold_bad++;
    end
    chk("b2b_hold", hold_bad, 0);
    chk("b2b_one_issue", issue_cnt - c0, 1);
    get_resp("b2b1", vecs[1].f, 1'b0);
    get_resp("b2b2", vecs[2].f, 1'b0);
    chk("b2b_two_issues", issue_cnt - c0, 2);

    // Backpressure: consumer stalled, six offered, one issued + four buffered.
    acc = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.iReqValid = (acc < 6);
      bus.iReqA     = vecs[acc % 5].a;
      bus.iReqB     = vecs[acc % 5].b;
      bus.iReqOp    = vecs[acc % 5].op;
      rdy           = bus.oReqReady;
      tick();
      if (rdy && acc < 6) acc++;
    end
    bus.iReqValid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_ready_low", 32'(bus.oReqReady), 0);
    chk("bp_held_f", bus.oResF, vecs[0].f);
    for (int i = 0; i < 5; i++) get_resp($sformatf("bp%0d", i), vecs[i].f, 1'b0);
    chk("bp_ready_back", 32'(bus.oReqReady), 1);

    // Reset while WAITing: no response, late done is stray.
    c0 = issue_cnt;
    push(vecs[3]);
    tick();
    tick();
    rv0 = rv_cnt;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    rst_chk("midrst");
    repeat (6) tick();
    chk("midrst_stray", 32'(bus.oStray), 1);
    chk("midrst_no_resp", rv_cnt - rv0, 0);
    chk("midrst_issues", issue_cnt - c0, 1);

`ifdef FP_ISSUE_TIMEOUT_EN
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("to_stray_clr", 32'(bus.oStray), 0);
    adder_en = 1'b0;
    push(vecs[0]);
    tick();
    tick();
    repeat (7) tick();
    chk("to_not_yet", 32'(bus.oResValid), 0);
    tick();
    chk("to_valid", 32'(bus.oResValid), 1);
    chk("to_err", 32'(bus.oResErr), 1);
    chk("to_f", bus.oResF, 32'h7FC0_0000);
    chk("to_no_stray", 32'(bus.oStray), 0);
    get_resp("to", 32'h7FC0_0000, 1'b1);
    adder_en  = 1'b1;
    stray_inj = 1'b1;
    tick();
    stray_inj = 1'b0;
    chk("to_late_stray", 32'(bus.oStray), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
